// File: rtl/uart_tx_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   - FSM state encoding (3-bit localparams)
//   - parity-type constants
//   - frame_bits(): number of bit periods in one frame
package uart_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // start + payload + optional parity + one or two stops
    function automatic int unsigned frame_bits(input int unsigned data_width,
                                               input logic        par_en,
                                               input logic        stop2);
        return 32'd2 + data_width + {31'd0, par_en} + {31'd0, stop2};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk       system clock
//   rst       synchronous active-low reset
//   restart   reload the counter for a fresh bit period (frame load)
//   prescale  clocks per bit; 0 is treated as 1
//   bit_done  high in the last clock of every bit period
module uart_baud_tick #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      restart,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done
);

    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [PRESCALE_WIDTH-1:0] reload;

    // Counting down from P-1 to 0 gives a period of P clocks; P=0 maps to 1.
    always_comb begin
        reload = '0;
        if (prescale != '0)
            reload = prescale - PRESCALE_WIDTH'(1);
    end

    assign bit_done = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (restart || bit_done)
            cnt <= reload;
        else
            cnt <= cnt - PRESCALE_WIDTH'(1);
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-word holding buffer.
// Frame: start(0), DATA_WIDTH payload bits LSB first, optional parity,
// one or two stop bits(1). Back-to-back words leave no idle gap.
// Ports:
//   clk         system clock (rising edge)
//   rst         synchronous active-low reset
//   p_data      payload word
//   data_valid  producer offers p_data
//   ready       holding buffer empty (registered)
//   par_en      append parity bit
//   par_type    0 = even, 1 = odd parity
//   stop2       1 = two stop bits
//   prescale    clocks per bit (0 treated as 1)
//   tx_out      serial line, idle high
//   busy        frame in progress
module uart_tx_param
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    output logic                      ready,
    input  logic                      par_en,
    input  logic                      par_type,
    input  logic                      stop2,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // holding buffer
    logic                      buf_full;
    logic [DATA_WIDTH-1:0]     buf_data;
    logic                      buf_par_en;
    logic                      buf_par_type;
    logic                      buf_stop2;
    logic [PRESCALE_WIDTH-1:0] buf_prescale;

    // frame in flight
    logic [2:0]                state;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_bit;
    logic [CNT_W-1:0]          bit_cnt;
    logic                      stop_cnt;
    logic                      cfg_par_en;
    logic                      cfg_stop2;
    logic [PRESCALE_WIDTH-1:0] cfg_prescale;

    logic                      accept;
    logic                      last_stop;
    logic                      load;
    logic                      bit_done;
    logic [PRESCALE_WIDTH-1:0] baud_prescale;

    assign ready     = ~buf_full;
    assign accept    = data_valid && !buf_full;
    assign last_stop = (state == ST_STOP) && bit_done && (stop_cnt == cfg_stop2);
    // accept needs an empty buffer and load a full one, so they never coincide
    assign load      = buf_full && ((state == ST_IDLE) || last_stop);

    // On load the timer must start with the new word's prescale, which is
    // only in the buffer during that cycle.
    assign baud_prescale = load ? buf_prescale : cfg_prescale;

    uart_baud_tick #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (load),
        .prescale (baud_prescale),
        .bit_done (bit_done)
    );

    // buffer occupancy
    always_ff @(posedge clk) begin
        if (!rst)
            buf_full <= 1'b0;
        else if (load)
            buf_full <= 1'b0;
        else if (accept)
            buf_full <= 1'b1;
    end

    // payload path (no reset; qualified by buf_full / state)
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data     <= p_data;
            buf_par_en   <= par_en;
            buf_par_type <= par_type;
            buf_stop2    <= stop2;
            buf_prescale <= prescale;
        end
        if (load) begin
            shift_reg <= buf_data;
            par_bit   <= (^buf_data) ^ (buf_par_type == PAR_ODD);
        end else if ((state == ST_DATA) && bit_done) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    // frame FSM; tx_out and busy are registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            tx_out       <= 1'b1;
            busy         <= 1'b0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            cfg_par_en   <= 1'b0;
            cfg_stop2    <= 1'b0;
            cfg_prescale <= '0;
        end else if (load) begin
            state        <= ST_START;
            tx_out       <= 1'b0;
            busy         <= 1'b1;
            cfg_par_en   <= buf_par_en;
            cfg_stop2    <= buf_stop2;
            cfg_prescale <= buf_prescale;
        end else if (bit_done) begin
            case (state)
                ST_START: begin
                    state   <= ST_DATA;
                    tx_out  <= shift_reg[0];
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (cfg_par_en) begin
                            state  <= ST_PARITY;
                            tx_out <= par_bit;
                        end else begin
                            state    <= ST_STOP;
                            tx_out   <= 1'b1;
                            stop_cnt <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        // shift_reg[0] is the bit now ending
                        tx_out  <= shift_reg[1];
                    end
                end
                ST_PARITY: begin
                    state    <= ST_STOP;
                    tx_out   <= 1'b1;
                    stop_cnt <= 1'b0;
                end
                ST_STOP: begin
                    if (stop_cnt == cfg_stop2) begin
                        state  <= ST_IDLE;
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param (8-bit and 5-bit instances).
// Expected line waveform is built per clock from the frame rules.
module tb_uart_tx_param;

    logic       clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    logic       rst;
    logic [8:0] p_data;
    logic       dv8, dv5;
    logic       par_en, par_type, stop2;
    logic [7:0] prescale;
    logic       rdy8, rdy5, tx8, tx5, busy8, busy5;
    logic       sel;
    logic       rdy_s, tx_s, busy_s;

    assign rdy_s  = sel ? rdy5  : rdy8;
    assign tx_s   = sel ? tx5   : tx8;
    assign busy_s = sel ? busy5 : busy8;

    uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) u_dut8 (
        .clk(clk_tb), .rst(rst), .p_data(p_data[7:0]), .data_valid(dv8),
        .ready(rdy8), .par_en(par_en), .par_type(par_type), .stop2(stop2),
        .prescale(prescale), .tx_out(tx8), .busy(busy8));

    uart_tx_param #(.DATA_WIDTH(5), .PRESCALE_WIDTH(8)) u_dut5 (
        .clk(clk_tb), .rst(rst), .p_data(p_data[4:0]), .data_valid(dv5),
        .ready(rdy5), .par_en(par_en), .par_type(par_type), .stop2(stop2),
        .prescale(prescale), .tx_out(tx5), .busy(busy5));

    int checks = 0;
    int errors = 0;

    logic exp_tx[$];
    logic exp_busy[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endtask

    // Reference frame: start, payload LSB first, parity, stop bit(s),
    // each held max(prescale,1) clocks with busy high.
    task automatic add_frame(input int w, input logic [8:0] d, input logic pe,
                             input logic pt, input logic s2, input int ps);
        logic bits[$];
        logic par;
        int   p;
        p = (ps == 0) ? 1 : ps;
        bits.push_back(1'b0);
        par = pt;
        for (int i = 0; i < w; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (pe) bits.push_back(par);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i])
            for (int j = 0; j < p; j++) begin
                exp_tx.push_back(bits[i]);
                exp_busy.push_back(1'b1);
            end
    endtask

    // Walk the expected queues one negedge per entry, starting just after an accept edge.
    task automatic run_stream(input string tag);
        for (int k = 0; k < exp_tx.size(); k++) begin
            @(negedge clk_tb);
            check($sformatf("%s_tx_c%0d", tag, k + 1), tx_s, exp_tx[k]);
            check($sformatf("%s_busy_c%0d", tag, k + 1), busy_s, exp_busy[k]);
        end
        exp_tx.delete();
        exp_busy.delete();
    endtask

    // Offer a word and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic drive(input logic [8:0] d, input logic pe, input logic pt,
                         input logic s2, input logic [7:0] ps);
        int n;
        p_data   = d;
        par_en   = pe;
        par_type = pt;
        stop2    = s2;
        prescale = ps;
        if (sel) dv5 = 1'b1; else dv8 = 1'b1;
        n = 0;
        while (!rdy_s && n < 200) begin
            @(negedge clk_tb);
            n++;
        end
        if (!rdy_s) check("drive_ready_timeout", rdy_s, 1);
        @(posedge clk_tb);
        #1;
        dv8 = 1'b0;
        dv5 = 1'b0;
    endtask

    task automatic single(input string tag, input logic [8:0] d, input logic pe,
                          input logic pt, input logic s2, input logic [7:0] ps);
        drive(d, pe, pt, s2, ps);
        check({tag, "_ready_after_accept"}, rdy_s, 0);
        add_idle(1);
        add_frame(sel ? 5 : 8, d, pe, pt, s2, int'(ps));
        add_idle(1);
        run_stream(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] da, db;
        logic       pea, pta, s2a, peb, ptb, s2b;
        logic [7:0] psa, psb;

        rst = 1'b0; dv8 = 1'b0; dv5 = 1'b0; sel = 1'b0;
        p_data = '0; par_en = 1'b0; par_type = 1'b0; stop2 = 1'b0; prescale = 8'd1;

        repeat (3) @(negedge clk_tb);
        check("reset_tx8", tx8, 1);
        check("reset_busy8", busy8, 0);
        check("reset_ready8", rdy8, 1);
        check("reset_tx5", tx5, 1);
        check("reset_busy5", busy5, 0);
        check("reset_ready5", rdy5, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk_tb);

        single("basic_a5",   9'h0A5, 1'b1, 1'b0, 1'b0, 8'd1);
        single("odd_a5",     9'h0A5, 1'b1, 1'b1, 1'b0, 8'd1);
        single("nopar_stop2", 9'h0A5, 1'b0, 1'b0, 1'b1, 8'd1);
        single("presc4_3c",  9'h03C, 1'b1, 1'b0, 1'b0, 8'd4);
        single("presc0_3c",  9'h03C, 1'b1, 1'b0, 1'b0, 8'd0);

        // back-to-back 0x11 then 0x22 held until accepted
        drive(9'h011, 1'b1, 1'b0, 1'b0, 8'd1);
        add_idle(1);
        add_frame(8, 9'h011, 1'b1, 1'b0, 1'b0, 1);
        add_frame(8, 9'h022, 1'b1, 1'b0, 1'b0, 1);
        add_idle(1);
        fork
            begin
                drive(9'h022, 1'b1, 1'b0, 1'b0, 8'd1);
                check("b2b_ready_after_accept2", rdy_s, 0);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk_tb);
                    check($sformatf("b2b_ready_hold_c%0d", i + 3), rdy_s, 0);
                end
                @(negedge clk_tb);
                check("b2b_ready_after_load2", rdy_s, 1);
            end
            run_stream("b2b");
        join

        // reset during data bit 3 of 0xFF
        drive(9'h0FF, 1'b0, 1'b0, 1'b0, 8'd1);
        repeat (6) @(negedge clk_tb);
        check("midrst_pre_busy", busy_s, 1);
        rst = 1'b0;
        @(negedge clk_tb);
        check("midrst_tx", tx_s, 1);
        check("midrst_busy", busy_s, 0);
        check("midrst_ready", rdy_s, 1);
        rst = 1'b1;
        repeat (3) @(negedge clk_tb);
        check("midrst_idle_tx", tx_s, 1);
        check("midrst_idle_busy", busy_s, 0);
        single("after_rst_5a", 9'h05A, 1'b1, 1'b1, 1'b0, 8'd2);

        // 5-bit instance
        sel = 1'b1;
        single("w5_15", 9'h015, 1'b1, 1'b0, 1'b0, 8'd1);

        // randomized back-to-back pairs with independent configs on either instance
        for (int it = 0; it < 16; it++) begin
            sel = $urandom_range(0, 1);
            da  = 9'($urandom); pea = $urandom_range(0, 1); pta = $urandom_range(0, 1);
            s2a = $urandom_range(0, 1); psa = 8'($urandom_range(0, 4));
            db  = 9'($urandom); peb = $urandom_range(0, 1); ptb = $urandom_range(0, 1);
            s2b = $urandom_range(0, 1); psb = 8'($urandom_range(0, 4));
            @(negedge clk_tb);
            drive(da, pea, pta, s2a, psa);
            add_idle(1);
            add_frame(sel ? 5 : 8, da, pea, pta, s2a, int'(psa));
            add_frame(sel ? 5 : 8, db, peb, ptb, s2b, int'(psb));
            add_idle(1);
            fork
                begin
                    drive(db, peb, ptb, s2b, psb);
                    check($sformatf("rnd%0d_ready_after_accept2", it), rdy_s, 0);
                end
                run_stream($sformatf("rnd%0d", it));
            join
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8-bit uartTX_top.
- Generalised data width.
- Runtime baud prescale (clocks per bit).
- Optional 1 or 2 stop bits; optional even/odd parity.
- One-word holding buffer with a ready/valid input handshake, so back-to-back frames go out with no idle gap.
- Sits between the system-side byte producer and the serial pin.

Parameters:
DATA_WIDTH, 8, payload bits per frame (legal 5..9).
PRESCALE_WIDTH, 8, width of prescale port.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
p_data  input  DATA_WIDTH  parallel payload, LSB transmitted first
data_valid  input  1  producer offers p_data this cycle
ready  output  1  holding buffer empty; word accepted when data_valid && ready at posedge
par_en  input  1  1 = parity bit appended
par_type  input  1  0 = even parity, 1 = odd parity
stop2  input  1  1 = two stop bits, 0 = one
prescale  input  PRESCALE_WIDTH  clocks per bit; value 0 treated as 1
tx_out  output  1  serial line, idle high
busy  output  1  high while any frame bit is on the line

Behaviour:
Reset
- Applied at any posedge with rst=0, including mid-frame.
- Result: tx_out=1, busy=0, ready=1, FSM=IDLE, holding buffer empty, counters 0.
- A partially sent frame is abandoned and is not resumed.

Accept
- On posedge with data_valid && ready: p_data, par_en, par_type, stop2 and prescale are latched into the holding buffer; ready goes to 0 next cycle.
- data_valid while ready=0 is ignored; the producer must hold the word.
- ready is registered (no combinational path from data_valid).

Load
- When the buffer is full and the FSM is in IDLE, or in the final clock of the last stop bit, the FSM takes the buffered word into its shift register and config registers.
- The buffer empties in the same cycle, so ready=1 next cycle.
- The config in effect is the one captured with that word; port changes mid-frame have no effect.

Latency
- Accept at edge N with FSM IDLE → load at N+1 → tx_out=0 (start) and busy=1 from N+2.

Bit timing
- Each bit holds tx_out for P = max(prescale,1) clocks, timed by a baud counter.
- The baud counter reloads at every bit boundary.

FSM: IDLE → START → DATA → (PARITY if par_en) → STOP → IDLE or START
- IDLE: tx_out=1, busy=0.
- START: tx_out=0, 1 bit.
- DATA: DATA_WIDTH bits, LSB first; bit counter runs 0..DATA_WIDTH-1.
- PARITY: tx_out = (^data) ^ par_type.
- STOP: tx_out=1 for 1 or 2 bits per stop2.
- Frame length = 1 + DATA_WIDTH + par_en + 1 + stop2 bits, i.e. P × that many clocks.

Back-to-back
- If a word is buffered at the final stop clock, START follows on the next clock.
- busy stays high continuously across the frames.

busy
- Falls on the clock after the last stop bit completes when no word is buffered.
- busy is registered; it is 1 exactly while the FSM ≠ IDLE.

Simultaneous accept and load
- When the buffer is empty, the FSM cannot load in the same cycle as the accept; loading always occurs at the next edge.

Decomposition:
Package uart_tx_pkg:
- state encoding localparams (IDLE, START, DATA, PARITY, STOP)
- parity-type constants (PAR_EVEN=0, PAR_ODD=1)
- function computing frame length in bits

Sub-module uart_baud_tick:
- PRESCALE_WIDTH down-counter
- inputs: clk, rst, restart, prescale
- output: 1-cycle bit_done pulse every max(prescale,1) clocks

The FSM, shift register, holding buffer and parity logic stay in uart_tx_param.

Test Plan:
- Basic frame: DATA_WIDTH=8, prescale=1, par_en=1, par_type=0, stop2=0, send 0xA5 → tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop); busy high exactly 11 cycles; start bit 2 cycles after accept.
- Parity and stop options:
  - 0xA5 with par_type=1 → parity bit 1.
  - par_en=0, stop2=1 → 11 bits (start, 8 data, 2 stops), no parity.
- Prescale: prescale=4, send 0x3C with parity → every bit held 4 clocks; busy high 44 cycles; prescale=0 behaves as prescale=1.
- Back-to-back: assert data_valid with 0x11, then 0x22 held until ready.
  - ready=0 from the cycle after the second accept until the second word loads.
  - busy continuous for 22 cycles (prescale=1).
  - Second start bit immediately follows the first stop bit.
- Reset mid-frame: rst=0 during DATA bit 3 of 0xFF → next edge tx_out=1, busy=0, ready=1; the next accepted word produces a clean full frame.
- Width parameter: DATA_WIDTH=5, send 5'h15, even parity → bits 0,1,0,1,0,1,1,1 (parity 1, stop 1); busy high 8 cycles.
